// File: rtl/div_meter_pkg.sv
// Shared widths, capture limits and meter FSM encoding for div_meter and its
// companion divider-side blocks.
package div_meter_pkg;

    localparam int PERIOD_W   = 10;
    localparam int D_W        = 8;
    localparam int PERIOD_MIN = 2;
    localparam int PERIOD_MAX = 512;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, on the last
// count of each wrap.
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk_50m,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tcnt_q, tcnt_d;

    always_comb begin
        tick   = (tcnt_q == LAST);
        tcnt_d = tick ? '0 : tcnt_q + CW'(1);
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/div_meter.sv
// Measures the period of fin in prescaled ticks and recovers the divider
// preload d = 256 - period/2; flags lock, out-of-range captures and loss of signal.
module div_meter
    import div_meter_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int MAX_TICKS = 1023,
    parameter int LOCK_CNT  = 3
) (
    input  logic                clk_50m,
    input  logic                reset,
    input  logic                fin,
    output logic [PERIOD_W-1:0] period,
    output logic [D_W-1:0]      d_out,
    output logic                valid,
    output logic                locked,
    output logic                range_err,
    output logic                timeout
);

    localparam int CAP_W = PERIOD_W + 1;
    localparam int LW    = $clog2(LOCK_CNT + 1);

    localparam logic [PERIOD_W-1:0] MAX_T   = PERIOD_W'(MAX_TICKS);
    localparam logic [CAP_W-1:0]    CAP_MIN = CAP_W'(PERIOD_MIN);
    localparam logic [CAP_W-1:0]    CAP_MAX = CAP_W'(PERIOD_MAX);
    localparam logic [LW-1:0]       LOCK_C  = LW'(LOCK_CNT);

    function automatic logic [PERIOD_W-1:0] pcnt_sat_inc(input logic [PERIOD_W-1:0] v);
        return (v >= MAX_T) ? v : v + PERIOD_W'(1);
    endfunction

    function automatic logic [LW-1:0] lock_sat_inc(input logic [LW-1:0] v);
        return (v >= LOCK_C) ? v : v + LW'(1);
    endfunction

    // Odd periods come from tick jitter; the half-period is floored.
    function automatic logic [D_W-1:0] recover_d(input logic [CAP_W-1:0] c);
        logic [D_W:0] t;
        t = 9'd256 - c[PERIOD_W-1:1];
        return t[D_W-1:0];
    endfunction

    function automatic logic within_one(input logic [CAP_W-1:0]    c,
                                        input logic [PERIOD_W-1:0] p);
        logic signed [CAP_W:0] diff;
        diff = $signed({1'b0, c}) - $signed({2'b00, p});
        return (diff >= -1) && (diff <= 1);
    endfunction

    logic [2:0]          sync_q, sync_d;
    logic                tick;
    logic                rise;
    logic [CAP_W-1:0]    cap;
    logic                in_range;

    meter_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] prev_cap_q, prev_cap_d;
    logic [LW-1:0]       lcnt_q, lcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [D_W-1:0]      d_q, d_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic                range_q, range_d;
    logic                timeout_q, timeout_d;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_50m (clk_50m),
        .reset   (reset),
        .tick    (tick)
    );

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous sample.
    always_comb begin
        sync_d   = {sync_q[1:0], fin};
        rise     = sync_q[1] & ~sync_q[2];
        cap      = {1'b0, pcnt_q} + CAP_W'(tick);
        in_range = (cap >= CAP_MIN) && (cap <= CAP_MAX);
    end

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        prev_cap_d = prev_cap_q;
        lcnt_d     = lcnt_q;
        period_d   = period_q;
        d_d        = d_q;
        valid_d    = 1'b0;
        range_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    pcnt_d = '0;
                    if (in_range) begin
                        period_d   = cap[PERIOD_W-1:0];
                        d_d        = recover_d(cap);
                        valid_d    = 1'b1;
                        prev_cap_d = cap[PERIOD_W-1:0];
                        lcnt_d     = within_one(cap, prev_cap_q) ? lock_sat_inc(lcnt_q) : LW'(1);
                    end else begin
                        range_d = 1'b1;
                        lcnt_d  = '0;
                    end
                end else if (pcnt_q == MAX_T) begin
                    state_d   = IDLE;
                    pcnt_d    = '0;
                    timeout_d = 1'b1;
                    lcnt_d    = '0;
                end else if (tick) begin
                    pcnt_d = pcnt_sat_inc(pcnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase

        locked_d = (lcnt_d == LOCK_C);
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            pcnt_q     <= '0;
            prev_cap_q <= '0;
            lcnt_q     <= '0;
            period_q   <= '0;
            d_q        <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            range_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            prev_cap_q <= prev_cap_d;
            lcnt_q     <= lcnt_d;
            period_q   <= period_d;
            d_q        <= d_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            range_q    <= range_d;
            timeout_q  <= timeout_d;
        end
    end

    assign period    = period_q;
    assign d_out     = d_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign range_err = range_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_div_meter.sv
// Randomised bench for div_meter: fin is generated with exact tick-multiple
// periods and every pulse is compared with a timestamp-based reference model.
module tb_div_meter;

    localparam int TD    = 10;
    localparam int MAXT  = 1023;
    localparam int LOCKN = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       fin;
    logic [9:0] period;
    logic [7:0] d_out;
    logic       valid;
    logic       locked;
    logic       range_err;
    logic       timeout;

    div_meter #(
        .TICK_DIV  (TD),
        .MAX_TICKS (MAXT),
        .LOCK_CNT  (LOCKN)
    ) dut (
        .clk_50m   (clk),
        .reset     (reset),
        .fin       (fin),
        .period    (period),
        .d_out     (d_out),
        .valid     (valid),
        .locked    (locked),
        .range_err (range_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: captures derive from the cycle distance between driven
    // rising edges; kind 0 = valid, 1 = range error, 2 = timeout.
    typedef struct {
        int kind;
        int cap;
        bit lk;
        int t;
    } ev_t;

    ev_t evq[$];
    bit  armed    = 1'b0;
    int  last_rise = 0;
    int  lockc    = 0;
    int  prevcap  = 0;
    int  exp_per  = 0;
    int  exp_d    = 0;
    bit  to_seen  = 1'b0;
    ev_t mon_e;

    function automatic int d_of(input int c);
        return (256 - c / 2) % 256;
    endfunction

    task automatic model_rise();
        ev_t e;
        int  c;
        if (!armed) begin
            armed = 1'b1;
        end else begin
            c = (cyc - last_rise) / TD;
            e.cap = c;
            e.t   = cyc;
            if (c >= 2 && c <= 512) begin
                if (c - prevcap <= 1 && prevcap - c <= 1) lockc = (lockc < LOCKN) ? lockc + 1 : LOCKN;
                else lockc = 1;
                prevcap = c;
                e.kind  = 0;
                e.lk    = (lockc == LOCKN);
            end else begin
                lockc  = 0;
                e.kind = 1;
                e.lk   = 1'b0;
            end
            evq.push_back(e);
        end
        last_rise = cyc;
    endtask

    task automatic drive_period(input int p);
        @(posedge clk);
        #2 fin = 1'b1;
        model_rise();
        repeat (p * TD / 2) @(posedge clk);
        #2 fin = 1'b0;
        repeat (p * TD / 2 - 1) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_d_out"}, d_out, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_range_err"}, range_err, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && (valid || range_err || timeout)) begin
            chk("one_pulse_only", 32'(valid) + 32'(range_err) + 32'(timeout), 1);
            if (evq.size() == 0) begin
                chk("unexpected_pulse", {29'd0, valid, range_err, timeout}, 0);
            end else begin
                mon_e = evq.pop_front();
                chk("pulse_kind", {29'd0, valid, range_err, timeout},
                    (mon_e.kind == 0) ? 4 : (mon_e.kind == 1) ? 2 : 1);
                if (mon_e.kind == 0) begin
                    exp_per = mon_e.cap;
                    exp_d   = d_of(mon_e.cap);
                end
                chk("period", period, exp_per);
                chk("d_out", d_out, exp_d);
                chk("locked", locked, mon_e.lk);
                if (mon_e.kind == 2) begin
                    chk("timeout_delay_in_window",
                        ((cyc - mon_e.t) >= MAXT * TD - 15 && (cyc - mon_e.t) <= MAXT * TD + 20), 1);
                    to_seen = 1'b1;
                end
            end
        end
    end

    initial begin
        int  p;
        ev_t te;
        reset = 1'b1;
        fin   = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        // Steady 256-tick input (d = 0x80), then +-1 tick jitter keeps lock.
        repeat (6) drive_period(256);
        drive_period(257);
        drive_period(256);
        drive_period(255);

        // Short periods down to the 2-tick boundary, then a 1-tick capture.
        repeat (4) drive_period(4);
        repeat (2) drive_period(2);
        drive_period(1);

        // 512-tick boundary (d = 0x00) must re-lock after three captures.
        repeat (4) drive_period(512);

        // Loss of signal after lock.
        te.kind = 2;
        te.cap  = 0;
        te.lk   = 1'b0;
        te.t    = last_rise;
        evq.push_back(te);
        to_seen = 1'b0;
        for (int i = 0; i < 11000 && !to_seen; i++) @(posedge clk);
        chk("timeout_seen", to_seen, 1);
        armed = 1'b0;
        lockc = 0;

        // Re-arm, one good capture, then out-of-range 600 and 513.
        drive_period(100);
        drive_period(600);
        drive_period(513);
        drive_period(256);

        // Alternating 256/300 never locks.
        drive_period(300);
        drive_period(256);
        drive_period(300);

        // Random steady period.
        p = $urandom_range(60, 2);
        repeat (4) drive_period(p);

        // Reset mid-measurement with fin low.
        @(posedge clk);
        #2 fin = 1'b1;
        model_rise();
        repeat (p * TD / 2) @(posedge clk);
        #2 fin = 1'b0;
        repeat (p * TD / 4 + 3) @(posedge clk);
        chk("queue_empty_before_reset", evq.size(), 0);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        armed   = 1'b0;
        lockc   = 0;
        prevcap = 0;
        exp_per = 0;
        exp_d   = 0;
        repeat (3) drive_period(50);

        repeat (20) @(posedge clk);
        chk("events_drained", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
